serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the legal range SHALL be 1 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when a result becomes valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result, low WIDTH bits of a+b+cin.
REQ-011 The block SHALL have port cout, output, 1 bit: registered carry-out, bit WIDTH of a+b+cin.

Function
REQ-012 The block SHALL compute a+b+cin bit-serially, LSB first, with one 1-bit full-add (s = x^y^c, c' = xy|xc|yc) per clock and a 1-bit carry register.
REQ-013 The FSM SHALL have the states IDLE, ADD and DONE.
REQ-014 IDLE: start=1 at an edge SHALL capture a, b and cin into internal shift and carry registers, clear the bit counter and enter ADD; start=0 SHALL stay in IDLE.
REQ-015 ADD: each edge SHALL process operand bit [counter], shift the sum bit into the partial-sum register MSB, update the carry register and increment the counter.
REQ-016 ADD: the edge processing bit WIDTH-1 SHALL load sum and cout from the completed partial result and carry, and SHALL enter DONE.
REQ-017 DONE: done SHALL be 1 for exactly this one cycle; the next edge SHALL enter ADD if start=1 (capturing new operands per REQ-014), otherwise IDLE.
REQ-018 busy SHALL be 1 exactly when the state is ADD; done SHALL be 1 exactly when the state is DONE; both SHALL be decoded from state with no combinational path from inputs.
REQ-019 Latency: if start is sampled at edge k, the block SHALL set busy=1 for edges k..k+WIDTH-1, set done=1 in the cycle following edge k+WIDTH, and update sum/cout at edge k+WIDTH.
REQ-020 start while in ADD SHALL be ignored, with no effect on state, operands or counter.
REQ-021 Changes on a, b or cin after capture SHALL NOT affect the result in progress.
REQ-022 sum and cout SHALL hold their value from completion until the next completion, and SHALL be unchanged during ADD.
REQ-023 The counter SHALL be ceil(log2(WIDTH+1)) bits; for WIDTH=1 the block SHALL spend exactly one cycle in ADD.
REQ-024 Back-to-back operation (start held high) SHALL sustain one result every WIDTH+1 cycles.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force state=IDLE, busy=0, done=0, sum=0, cout=0, clear the counter, carry and shift registers, and abort any addition in progress with no done pulse.
REQ-026 After rst_n rises, the first start sampled on a rising clk edge SHALL be accepted normally.

Verification
REQ-027 The bench SHALL check: WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulse at edge k -> busy=1 for 8 cycles, done=1 after edge k+8, sum=8'h00, cout=1.
REQ-028 The bench SHALL check: a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; then a=8'h12, b=8'h34, cin=0 -> sum=8'h46, cout=0.
REQ-029 The bench SHALL check: start pulsed again at edge k+3 and a/b changed mid-ADD -> first result unaffected, done pulses once.
REQ-030 The bench SHALL check: rst_n driven low at edge k+4 mid-ADD -> outputs 0 immediately, no done pulse; a new start after release -> correct result.
REQ-031 The bench SHALL check: start held high for three operand pairs -> done every 9 cycles, with each sum/cout matching a+b+cin.
REQ-032 The bench SHALL check: exhaustive WIDTH=1 instance over all 8 input combinations -> {cout,sum} equals a+b+cin, done 2 cycles after start.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-add per clock, LSB first.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   start         - begin an addition (sampled in IDLE or DONE)
//   a, b, cin     - operands and carry-in, captured on accept
//   busy          - high while bits are being added
//   done          - one-cycle pulse when sum/cout are updated
//   sum, cout     - registered result of a+b+cin
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // acc holds the unprocessed bits of A in its low end and collects
    // sum bits at its MSB; after WIDTH shifts it is the full sum.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic s_bit;
    logic c_bit;
    logic last;
    logic capture;

    assign s_bit = acc[0] ^ opb[0] ^ carry;
    assign c_bit = (acc[0] & opb[0])
                 | (acc[0] & carry)
                 | (opb[0] & carry);

    assign acc_nx = (acc >> 1)
                  | (WIDTH'(s_bit) << (WIDTH - 1));

    assign last = (cnt == CW'(WIDTH - 1));

    // DONE accepts a new start directly so back-to-back runs
    // cost only one extra cycle per result.
    assign capture = start &&
                     ((state == IDLE) || (state == DONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? ADD : IDLE;
            ADD:     state_nx = last ? DONE : ADD;
            DONE:    state_nx = start ? ADD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (1'b1)
            (state == ADD):  busy = 1'b1;
            (state == DONE): done = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (capture) begin
            acc   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ADD) begin
            acc   <= acc_nx;
            opb   <= opb >> 1;
            carry <= c_bit;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= acc_nx;
                cout <= c_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector bench for serial_adder
// (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    typedef struct {
        logic       a;
        logic       b;
        logic       cin;
        logic [1:0] exp;
    } vec1_t;

    vec_t  tv[7];
    vec1_t t1[8];
    vec_t  bp[3];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h",
                      name, act, exp);
    endtask

    // Starts one WIDTH=8 addition and waits (bounded) for done.
    task automatic run8(input logic [7:0] va,
                        input logic [7:0] vb,
                        input logic       vc,
                        output int        bcyc,
                        output int        dcyc,
                        output bit        held);
        logic [7:0] prev;
        bcyc = 0;
        dcyc = 0;
        held = 1'b1;
        @(negedge clk);
        prev  = sum;
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dcyc = i;
                break;
            end
            if (busy) bcyc++;
            if (sum !== prev) held = 1'b0;
        end
    endtask

    initial begin
        int  bc;
        int  dc;
        bit  hd;
        int  ndone;
        int  first;
        int  p;
        int  cyc;

        tv[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tv[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tv[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        tv[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tv[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tv[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tv[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};

        t1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
        t1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
        t1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
        t1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
        t1[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
        t1[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
        t1[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
        t1[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

        bp[0] = '{8'h11, 8'h22, 1'b0, 8'h33, 1'b0};
        bp[1] = '{8'hF0, 8'h20, 1'b1, 8'h11, 1'b1};
        bp[2] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};

        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;

        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst sum",  32'(sum),  0);
        check("rst cout", 32'(cout), 0);
        rst_n = 1'b1;

        // Table of single additions
        for (int i = 0; i < 7; i++) begin
            run8(tv[i].a, tv[i].b, tv[i].cin, bc, dc, hd);
            check($sformatf("v%0d busy", i), 32'(bc), 8);
            check($sformatf("v%0d lat", i), 32'(dc), 9);
            check($sformatf("v%0d hold", i), 32'(hd), 1);
            check($sformatf("v%0d sum", i), 32'(sum), 32'(tv[i].s));
            check($sformatf("v%0d cout", i), 32'(cout), 32'(tv[i].co));
            @(negedge clk);
            check($sformatf("v%0d pulse", i), 32'(done), 0);
        end

        // Second start and operand change while adding
        @(negedge clk);
        a     = 8'h3C;
        b     = 8'h0F;
        cin   = 1'b0;
        start = 1'b1;
        ndone = 0;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) begin
                a   = 8'hFF;
                b   = 8'hFF;
                cin = 1'b1;
            end
            if (i == 3) start = 1'b1;
            if (done) begin
                ndone++;
                if (first == 0) first = i;
            end
        end
        check("mid done cnt", 32'(ndone), 1);
        check("mid done cyc", 32'(first), 9);
        check("mid sum",  32'(sum),  32'h4B);
        check("mid cout", 32'(cout), 0);

        // Reset in the middle of an addition
        @(negedge clk);
        a     = 8'h55;
        b     = 8'h22;
        cin   = 1'b0;
        start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-rst busy", 32'(busy), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async busy", 32'(busy), 0);
        check("async done", 32'(done), 0);
        check("async sum",  32'(sum),  0);
        check("async cout", 32'(cout), 0);
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort no done", 32'(ndone), 0);
        run8(8'h55, 8'h22, 1'b0, bc, dc, hd);
        check("post-rst lat",  32'(dc),   9);
        check("post-rst sum",  32'(sum),  32'h77);
        check("post-rst cout", 32'(cout), 0);

        // Back-to-back with start held high
        @(negedge clk);
        a     = bp[0].a;
        b     = bp[0].b;
        cin   = bp[0].cin;
        start = 1'b1;
        p     = 0;
        cyc   = 0;
        for (int i = 0; i < 60 && p < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                check($sformatf("b2b%0d gap", p), 32'(cyc), 9);
                check($sformatf("b2b%0d sum", p), 32'(sum), 32'(bp[p].s));
                check($sformatf("b2b%0d cout", p), 32'(cout), 32'(bp[p].co));
                p++;
                cyc = 0;
                if (p < 3) begin
                    a   = bp[p].a;
                    b   = bp[p].b;
                    cin = bp[p].cin;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b results", 32'(p), 3);

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1     = t1[i].a;
            b1     = t1[i].b;
            cin1   = t1[i].cin;
            start1 = 1'b1;
            dc     = 0;
            for (int j = 1; j <= 10; j++) begin
                @(negedge clk);
                start1 = 1'b0;
                if (done1) begin
                    dc = j;
                    break;
                end
            end
            check($sformatf("w1 %0d lat", i), 32'(dc), 2);
            check($sformatf("w1 %0d res", i),
                  32'({cout1, sum1}), 32'(t1[i].exp));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
